// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and tree-sizing helpers for the parity stream accumulator
package parity_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Sideband carried alongside the partial parities through every tree level.
   typedef struct packed {
      logic valid;
      logic last;
      logic mode;
      logic chk_en;
      logic chk;
   } tok_t;

   // Number of nodes at a given tree level; level 0 is the raw data word.
   function automatic int level_nodes(input int width, input int fanin, input int level);
      int n;
      n = width;
      for (int i = 0; i < level; i++) begin
         n = (n + fanin - 1) / fanin;
      end
      return n;
   endfunction

   // A 1-bit word still gets one registered level so latency stays uniform.
   function automatic int tree_levels(input int width, input int fanin);
      int n;
      int l;
      n = width;
      l = 0;
      while (n > 1) begin
         n = (n + fanin - 1) / fanin;
         l++;
      end
      return (l < 1) ? 1 : l;
   endfunction

   // Bit offset of a level inside the flattened tree bus (levels packed back to back).
   function automatic int level_offset(input int width, input int fanin, input int level);
      int s;
      s = 0;
      for (int i = 0; i < level; i++) begin
         s += level_nodes(width, fanin, i);
      end
      return s;
   endfunction

endpackage

// File: rtl/xor_reduce_stage.sv
// rtl/xor_reduce_stage.sv - one registered XOR tree level with hold and synchronous clear
//   clk, rst   : clock, synchronous active-high clear of all stage state
//   i_hold     : keep the current contents (downstream stall)
//   i_tok      : sideband token entering the level
//   i_data     : N_IN partial parities from the previous level
//   o_tok      : registered token
//   o_data     : N_OUT registered partial parities, N_OUT = ceil(N_IN / FANIN)
module xor_reduce_stage
   import parity_pkg::*;
#(
   parameter  int N_IN  = 5,
   parameter  int FANIN = 4,
   localparam int N_OUT = (N_IN + FANIN - 1) / FANIN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_hold,
   input  tok_t             i_tok,
   input  logic [N_IN-1:0]  i_data,
   output tok_t             o_tok,
   output logic [N_OUT-1:0] o_data
);

   logic [N_OUT*FANIN-1:0] w_pad;
   logic [N_OUT-1:0]       w_par;
   tok_t                   r_tok;
   logic [N_OUT-1:0]       r_data;

   // The last node of a partly filled level sees zeros on its missing inputs.
   assign w_pad = (N_OUT*FANIN)'(i_data);

   always_comb begin
      w_par = '0;
      for (int j = 0; j < N_OUT; j++) begin
         w_par[j] = ^w_pad[j*FANIN +: FANIN];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tok  <= '0;
         r_data <= '0;
      end else if (!i_hold) begin
         r_tok  <= i_tok;
         r_data <= w_par;
      end
   end

   assign o_tok  = r_tok;
   assign o_data = r_data;

endmodule

// File: rtl/parity_stream_accum.sv
// rtl/parity_stream_accum.sv - pipelined per-frame parity engine with check and saturating count
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : word stream, in_last marks the frame's final word
//   in_odd                        : parity mode, taken from the first word of a frame
//   in_chk_en, in_chk             : expected-parity check, taken from the last word
//   out_valid/out_ready           : frame result handshake
//   out_parity, out_err, out_count: frame parity, check failure, saturating word count
module parity_stream_accum
   import parity_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int FANIN = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             in_odd,
   input  logic             in_chk_en,
   input  logic             in_chk,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_parity,
   output logic             out_err,
   output logic [CNT_W-1:0] out_count
);

   localparam int              L       = tree_levels(WIDTH, FANIN);
   localparam int              TREE_W  = level_offset(WIDTH, FANIN, L + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              w_stall;
   tok_t [L:0]        w_tok;
   logic [TREE_W-1:0] w_tree;
   tok_t              w_fin;
   logic              w_word_par;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_acc;
   logic              w_acc_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_mode;
   logic              w_mode_nxt;
   logic              w_emit;
   logic              w_res_par;

   logic              r_out_valid;
   logic              r_out_parity;
   logic              r_out_err;
   logic [CNT_W-1:0]  r_out_count;

   // Only a result that cannot leave blocks the pipe, so one result per cycle is sustainable.
   assign w_stall  = r_out_valid & ~out_ready;
   assign in_ready = ~w_stall;

   assign w_tok[0] = '{valid:  in_valid & ~w_stall,
                       last:   in_last,
                       mode:   in_odd,
                       chk_en: in_chk_en,
                       chk:    in_chk};
   assign w_tree[WIDTH-1:0] = in_data;

   for (genvar k = 1; k <= L; k++) begin : g_lvl
      localparam int NI = level_nodes(WIDTH, FANIN, k - 1);
      localparam int NO = level_nodes(WIDTH, FANIN, k);
      localparam int OI = level_offset(WIDTH, FANIN, k - 1);
      localparam int OO = level_offset(WIDTH, FANIN, k);

      xor_reduce_stage #(
         .N_IN  (NI),
         .FANIN (FANIN)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .i_hold (w_stall),
         .i_tok  (w_tok[k-1]),
         .i_data (w_tree[OI +: NI]),
         .o_tok  (w_tok[k]),
         .o_data (w_tree[OO +: NO])
      );
   end

   // The final level always has exactly one node: the word parity.
   assign w_fin      = w_tok[L];
   assign w_word_par = w_tree[TREE_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_acc   <= 1'b0;
         r_cnt   <= '0;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mode  <= w_mode_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_mode_nxt  = r_mode;
      w_emit      = 1'b0;
      w_res_par   = 1'b0;
      if (w_fin.valid && !w_stall) begin
         case (r_state)
            IDLE: begin
               // First word of a frame: mode comes from this token, acc is known zero.
               w_mode_nxt = w_fin.mode;
               w_cnt_nxt  = CNT_W'(1);
               w_res_par  = w_word_par ^ w_fin.mode;
               if (w_fin.last) begin
                  w_emit    = 1'b1;
                  w_acc_nxt = 1'b0;
               end else begin
                  w_acc_nxt   = w_word_par;
                  w_state_nxt = ACTIVE;
               end
            end
            ACTIVE: begin
               w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
               w_res_par = r_acc ^ w_word_par ^ r_mode;
               if (w_fin.last) begin
                  w_emit      = 1'b1;
                  w_acc_nxt   = 1'b0;
                  w_state_nxt = IDLE;
               end else begin
                  w_acc_nxt = r_acc ^ w_word_par;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // Emission only happens when not stalled, so it never overwrites an unconsumed result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_parity <= 1'b0;
         r_out_err    <= 1'b0;
         r_out_count  <= '0;
      end else if (w_emit) begin
         r_out_valid  <= 1'b1;
         r_out_parity <= w_res_par;
         r_out_err    <= w_fin.chk_en & (w_res_par ^ w_fin.chk);
         r_out_count  <= w_cnt_nxt;
      end else if (r_out_valid && out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_parity = r_out_parity;
   assign out_err    = r_out_err;
   assign out_count  = r_out_count;

endmodule

// File: doc/parity_stream_accum.md
# parity_stream_accum

Parametrised, pipelined parity engine for streamed words. Each WIDTH-bit word is reduced by a registered XOR tree, and per-word parities are accumulated across a frame delimited by `in_last`. One parity result per frame is emitted with even/odd mode, an optional check against an expected bit, and a saturating word count. The block sits between a ready/valid data source and a ready/valid result consumer. It is the sequential, generalised successor to the team's fixed-width combinational parity benchmarks.

## Interface
- `WIDTH`, 5, data word width in bits, ≥1.
- `FANIN`, 4, XOR inputs per tree node, ≥2.
- `CNT_W`, 16, width of the per-frame word counter, ≥1.
- `clk` in 1, sole clock; all state updates on the rising edge.
- `rst` in 1, reset: synchronous and active-high.
- `in_valid` in 1, input word present.
- `in_ready` out 1, block accepts a word this cycle.
- `in_data` in WIDTH, data word.
- `in_last` in 1, word is the final word of its frame.
- `in_odd` in 1, parity mode, sampled only on the first word of a frame: 0 = even, 1 = odd.
- `in_chk_en` in 1, check enable, sampled with the `in_last` word.
- `in_chk` in 1, expected parity, sampled with the `in_last` word.
- `out_valid` out 1, frame result present.
- `out_ready` in 1, consumer accepts the result.
- `out_parity` out 1, frame parity: XOR of all frame bits XOR the frame's mode bit.
- `out_err` out 1, `in_chk_en && (out_parity != in_chk)`; 0 when the check is disabled.
- `out_count` out CNT_W, number of words in the frame, saturating at 2^CNT_W−1.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Stall:
  - `stall = out_valid && !out_ready`.
  - `in_ready = !stall`.
  - While stalled, every pipeline register, the accumulator and the counter hold their values.
- XOR tree:
  - The tree has L = max(1, ceil(log_FANIN(WIDTH))) levels, and every level is registered.
  - Each stage carries a token: valid, last, per-node partial parities, the mode bit, `chk_en` and `chk`.
  - When a level is not full, the missing node inputs are zero.
- Frame FSM, two states:
  - IDLE: no frame open. A token reaching the accumulator captures the mode bit and sets count = 1.
    - If that token has last=0, go to ACTIVE.
    - If it has last=1, stay in IDLE and emit the result.
  - ACTIVE: each token XORs its word parity into `acc` and increments count, saturating.
    - A token with last=1 emits the result and returns to IDLE.
- Result: `out_parity = acc ^ word_par ^ mode`.
  - `acc` is cleared on emission.
  - The result register loads on emission and stays held until the output transfer.
  - `out_valid` drops after the transfer unless a new result loads in the same cycle.
- Frames are never empty, because the `in_last` word itself counts.
- A bubble (`in_valid=0`) mid-frame is legal and does not affect the result.
- `in_odd` on non-first words is ignored. `in_chk_en` and `in_chk` on non-last words are ignored.

## Timing
- Reset values: `out_valid=0`, `out_parity=0`, `out_err=0`, `out_count=0`, `in_ready=1`; all tokens invalid; `acc=0`; count = 0; FSM in IDLE.
- Latency: a last word accepted in cycle t gives `out_valid=1` in cycle t+L+1 when there is no stall. With the defaults, L=2 and latency is 3.
- Throughput: one word per cycle. Back-to-back frames, including single-word frames on consecutive cycles, produce one result per cycle when `out_ready=1`.
- Simultaneous output transfer and new result in the same cycle: the new result loads and `out_valid` stays 1.
- Reset mid-frame or mid-stall: all in-flight tokens and any partial frame are discarded. Words accepted after reset start a new frame.
- Count saturation: the counter holds at 2^CNT_W−1; parity stays exact.

## Structure
- Package `parity_pkg`:
  - function `tree_levels(WIDTH, FANIN)`;
  - function `level_nodes(level)`;
  - FSM state enum `{IDLE, ACTIVE}`.
- Sub-module `xor_reduce_stage`: one registered tree level, parametrised by input count and FANIN, with hold enable and synchronous clear. It is instantiated L times by generate.
- The top level contains the FSM, accumulator, counter, result register and stall logic.

## Test plan
All scenarios use WIDTH=5, FANIN=4, CNT_W=16 unless stated.
- Single-word frame, even mode: `5'b10110` with last → `out_parity=1`, `out_count=1`, `out_valid` 3 cycles after acceptance.
- Three-word frame: words `00001`, `00011`, `11111`.
  - Even mode → `out_parity=0`, `out_count=3`.
  - The same frame in odd mode → `out_parity=1`.
- Check mode: same three-word frame, even mode, `in_chk_en=1`.
  - `in_chk=1` → `out_err=1`.
  - `in_chk=0` → `out_err=0`.
- Backpressure: hold `out_ready=0` for 5 cycles with a result pending → `in_ready=0` and the result stays stable. The following frames stay unchanged; releasing gives one result per cycle, in order.
- Reset mid-frame: accept 2 words, assert `rst` for one cycle, then send the single-word frame `00111` (even mode) → exactly one result, `out_parity=1`, `out_count=1`.
- Saturation: CNT_W=2, a 6-word frame of `00001` → `out_count=3`, `out_parity=0`.
